// File: rtl/patch_streamer.sv
// Snapshots the patchifier's finished patch array and replays it as a valid/ready pixel stream,
// one pixel per beat, patch-major then position-minor, tagged with indices and framing flags.
module patch_streamer #(
  parameter int unsigned CHANNEL_SIZE      = 8,
  parameter int unsigned NUM_CHANNELS      = 3,
  parameter int unsigned PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS,
  parameter int unsigned IMG_WIDTH         = 16,
  parameter int unsigned IMG_HEIGHT        = 16,
  parameter int unsigned PATCH_SIZE        = 4,
  parameter int unsigned TOTAL_NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE),
  parameter int unsigned PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE,
  parameter int unsigned PIDX_W            = $clog2(TOTAL_NUM_PATCHES),
  parameter int unsigned QIDX_W            = $clog2(PATCH_VECTOR_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             patch_state,
  input  logic [PIXEL_WIDTH-1:0] all_patches [TOTAL_NUM_PATCHES][PATCH_VECTOR_SIZE],
  output logic                   output_taken,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH-1:0] out_data,
  output logic [PIDX_W-1:0]      out_patch_idx,
  output logic [QIDX_W-1:0]      out_pos_idx,
  output logic                   out_last_in_patch,
  output logic                   out_last,
  output logic                   busy,
  output logic [7:0]             frame_count
);

  localparam logic [2:0]        StateDone = 3'b100;
  localparam logic [QIDX_W-1:0] LastPos   = QIDX_W'(PATCH_VECTOR_SIZE - 1);
  localparam logic [PIDX_W-1:0] LastPatch = PIDX_W'(TOTAL_NUM_PATCHES - 1);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e state_q;
  logic   capture;

  logic [PIXEL_WIDTH-1:0] buffer_q [TOTAL_NUM_PATCHES][PATCH_VECTOR_SIZE];

  assign capture = (state_q == StIdle) && (patch_state == StateDone);

  // Buffer carries no reset; it is only read while out_valid is high.
  always_ff @(posedge clk) begin
    if (capture) begin
      buffer_q <= all_patches;
    end
  end

  always_comb begin
    out_data          = buffer_q[out_patch_idx][out_pos_idx];
    out_last_in_patch = (out_pos_idx == LastPos);
    out_last          = out_last_in_patch && (out_patch_idx == LastPatch);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      output_taken  <= 1'b0;
      out_valid     <= 1'b0;
      out_patch_idx <= '0;
      out_pos_idx   <= '0;
      busy          <= 1'b0;
      frame_count   <= 8'd0;
    end else begin
      output_taken <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (capture) begin
            state_q       <= StStream;
            output_taken  <= 1'b1;
            out_valid     <= 1'b1;
            busy          <= 1'b1;
            out_patch_idx <= '0;
            out_pos_idx   <= '0;
          end
        end
        StStream: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              state_q       <= StIdle;
              out_valid     <= 1'b0;
              busy          <= 1'b0;
              out_patch_idx <= '0;
              out_pos_idx   <= '0;
              frame_count   <= frame_count + 8'd1;
            end else if (out_last_in_patch) begin
              out_pos_idx   <= '0;
              out_patch_idx <= out_patch_idx + 1'b1;
            end else begin
              out_pos_idx   <= out_pos_idx + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_patch_streamer.sv
// Self-checking bench for patch_streamer: randomized images and backpressure checked against
// a flat beat-number model of the expected stream.
module tb_patch_streamer;
  localparam int NP = 16;
  localparam int PV = 16;
  localparam int PW = 24;
  localparam int NBEATS = NP * PV;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    patch_state = 3'b000;
  logic [PW-1:0] all_patches [NP][PV];
  logic [PW-1:0] model [NP][PV];
  logic          output_taken, out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_data;
  logic [3:0]    out_patch_idx, out_pos_idx;
  logic          out_last_in_patch, out_last, busy;
  logic [7:0]    frame_count;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;

  always #5 clk = ~clk;

  patch_streamer dut (
    .clk              (clk),
    .reset            (reset),
    .patch_state      (patch_state),
    .all_patches      (all_patches),
    .output_taken     (output_taken),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_patch_idx    (out_patch_idx),
    .out_pos_idx      (out_pos_idx),
    .out_last_in_patch(out_last_in_patch),
    .out_last         (out_last),
    .busy             (busy),
    .frame_count      (frame_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_pattern(input bit rnd);
    for (int p = 0; p < NP; p++) begin
      for (int q = 0; q < PV; q++) begin
        model[p][q] = rnd ? PW'($urandom) : {p[7:0], q[7:0], 8'hA5};
      end
    end
    all_patches = model;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_taken"}, output_taken, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_frames"}, frame_count, exp_frames[7:0]);
  endtask

  // Offers DONE, expects capture on the next edge, then streams stop_at beats with
  // out_ready high pct% of the time. Beat n must carry model[n/PV][n%PV].
  task automatic run_image(input int pct, input bit overwrite, input bit keep_done,
                           input int stop_at);
    int  n = 0;
    int  cyc = 0;
    bit  rdy;
    patch_state = 3'b100;
    while (!output_taken && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("capture_latency", cyc, 1);
    if (!keep_done) patch_state = 3'b010;
    if (overwrite) begin
      for (int p = 0; p < NP; p++)
        for (int q = 0; q < PV; q++) all_patches[p][q] = '0;
    end
    cyc = 0;
    while (n < stop_at && cyc < 4000) begin
      rdy = ($urandom_range(99) < pct);
      out_ready = rdy;
      check("valid", out_valid, 1'b1);
      check("busy", busy, 1'b1);
      check("taken_pulse", output_taken, (cyc == 0));
      check("patch_idx", out_patch_idx, n / PV);
      check("pos_idx", out_pos_idx, n % PV);
      check("data", out_data, model[n / PV][n % PV]);
      check("last_in_patch", out_last_in_patch, (n % PV) == PV - 1);
      check("last", out_last, n == NBEATS - 1);
      @(posedge clk); #1;
      cyc++;
      if (rdy) n++;
    end
    check("beat_count", n, stop_at);
    if (stop_at == NBEATS) begin
      exp_frames = (exp_frames + 1) % 256;
      check_idle("end_of_image");
    end
  endtask

  initial begin
    load_pattern(1'b0);
    #12;
    check("reset_patch_idx", out_patch_idx, 4'd0);
    check("reset_pos_idx", out_pos_idx, 4'd0);
    check_idle("reset");
    @(negedge clk);
    reset = 1'b0;
    patch_state = 3'b010;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check_idle("idle");
    end

    // Single image, ready tied high, reference pattern
    run_image(100, 1'b0, 1'b0, NBEATS);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_idle("post_image");
    end

    // Backpressure with random data
    load_pattern(1'b1);
    run_image(50, 1'b0, 1'b0, NBEATS);

    // Source overwritten right after the snapshot
    load_pattern(1'b1);
    run_image(100, 1'b1, 1'b0, NBEATS);

    // DONE held across two images: one capture each, one idle cycle between
    load_pattern(1'b1);
    run_image(100, 1'b0, 1'b1, NBEATS);
    load_pattern(1'b1);
    run_image(70, 1'b0, 1'b1, NBEATS);
    check("two_frames_held_done", frame_count, 8'd5);

    // Asynchronous reset mid-stream at beat 100, DONE still present
    load_pattern(1'b1);
    run_image(100, 1'b0, 1'b1, 100);
    #2 reset = 1'b1;
    #1;
    exp_frames = 0;
    check_idle("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    run_image(100, 1'b0, 1'b0, NBEATS);
    check("frames_after_reset", frame_count, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/patch_streamer.md
Name: patch_streamer

Overview:
- Downstream stage of the patchifier.
- Waits for the patchifier to report DONE (state 3'b100), snapshots its full all_patches array into a local buffer, and acknowledges with a one-cycle output_taken pulse. Releasing the patchifier early lets it accept the next image.
- Replays the buffered patches one pixel per beat over a valid/ready stream, tagged with patch index, position index and framing flags, for the token/embedding stage.

Parameters:
- CHANNEL_SIZE, 8, bits per colour channel
- NUM_CHANNELS, 3, channels per pixel
- PIXEL_WIDTH, CHANNEL_SIZE*NUM_CHANNELS, pixel word width
- IMG_WIDTH, 16, image width in pixels
- IMG_HEIGHT, 16, image height in pixels
- PATCH_SIZE, 4, patch edge length in pixels
- TOTAL_NUM_PATCHES, (IMG_WIDTH/PATCH_SIZE)*(IMG_HEIGHT/PATCH_SIZE), patches per image
- PATCH_VECTOR_SIZE, PATCH_SIZE*PATCH_SIZE, pixels per patch
- PIDX_W, $clog2(TOTAL_NUM_PATCHES), patch index width
- QIDX_W, $clog2(PATCH_VECTOR_SIZE), position index width

Ports:
- clk  input  1  clock; single clock domain
- reset  input  1  asynchronous, active-high reset
- patch_state  input  3  patchifier state; 3'b100 = DONE, all other values = not ready
- all_patches  input  [PIXEL_WIDTH-1:0] x [TOTAL_NUM_PATCHES][PATCH_VECTOR_SIZE]  patchifier output array
- output_taken  output  1  one-cycle pulse acknowledging the snapshot to the patchifier
- out_valid  output  1  stream beat valid
- out_ready  input  1  downstream accepts the beat
- out_data  output  PIXEL_WIDTH  pixel word
- out_patch_idx  output  PIDX_W  patch index of the current beat
- out_pos_idx  output  QIDX_W  position of the beat within its patch
- out_last_in_patch  output  1  high when out_pos_idx == PATCH_VECTOR_SIZE-1
- out_last  output  1  final beat of the image
- busy  output  1  high in STREAM state
- frame_count  output  8  count of completed images; wraps 255 -> 0

Behaviour:
- Reset (asynchronous assert, applies immediately):
  - state=IDLE; output_taken=0, out_valid=0, out_patch_idx=0, out_pos_idx=0, frame_count=0, busy=0.
  - out_last, out_last_in_patch and out_data are decoded from the indices and buffer, so they are don't-care while out_valid=0.
  - The buffer has no reset.
- FSM states: IDLE, STREAM.
- IDLE -> STREAM on a clock edge where patch_state==3'b100. On that same edge:
  - buffer <= all_patches (whole array, one cycle);
  - output_taken <= 1; indices <= 0; out_valid <= 1.
- output_taken is high for exactly the first STREAM cycle, then 0. It is never asserted outside that cycle.
- Latency: beat 0 is valid in the cycle right after the DONE sample edge.
- STREAM beat rules:
  - out_data = buffer[out_patch_idx][out_pos_idx].
  - A transfer occurs on an edge with out_valid && out_ready.
  - While out_valid && !out_ready, out_data, the indices and the flags hold stable.
- Index advance on each transfer:
  - pos_idx increments;
  - at PATCH_VECTOR_SIZE-1, pos_idx wraps to 0 and patch_idx increments.
- Ordering: patch-major, position-minor, matching the patchifier layout (patch p = row-major patch grid, position q = row-major within the patch).
- Last beat (patch_idx==TOTAL_NUM_PATCHES-1 and pos_idx==PATCH_VECTOR_SIZE-1) transferred:
  - out_valid <= 0, indices <= 0, frame_count <= frame_count+1 (mod 256), state <= IDLE.
- Back-to-back images: a new snapshot can start no earlier than the edge after returning to IDLE, so there is at least one idle cycle between images. Minimum image time is TOTAL_NUM_PATCHES*PATCH_VECTOR_SIZE + 1 cycles.
- patch_state==DONE while in STREAM is ignored: no snapshot, no output_taken. The patchifier stays in DONE until this block returns to IDLE and captures.
- all_patches changes after the snapshot edge have no effect on the stream in flight.
- Reset mid-stream: the image is dropped, state returns to IDLE, and frame_count is cleared. If patch_state is still DONE after reset deassertion, a fresh snapshot and output_taken follow.

Test Plan:
- Reset then idle: patch_state=3'b010 for 20 cycles -> out_valid=0, output_taken=0, busy=0, frame_count=0.
- Single image, ready tied high: all_patches[p][q]={p[7:0],q[7:0],8'hA5}, patch_state=3'b100 for 1 cycle -> output_taken pulses once; 256 consecutive beats; beat n has patch_idx=n/16, pos_idx=n%16, data matches; out_last_in_patch on every 16th beat; out_last only on beat 255; frame_count=1; busy drops.
- Backpressure: out_ready toggled pseudo-randomly (about 50%) -> data/indices hold while stalled; no beat lost or duplicated; exactly 256 transfers.
- Snapshot isolation: overwrite all_patches with 0 one cycle after output_taken -> streamed data equals the pre-overwrite pattern.
- DONE during stream: hold patch_state=3'b100 throughout -> one output_taken per image; second image starts 1 cycle after out_last transfer; frame_count reaches 2 after 513+ cycles.
- Reset mid-operation: assert reset asynchronously (between edges) at beat 100 -> out_valid drops immediately; frame_count=0; after release with DONE present, streaming restarts at patch 0, position 0.
